// File: rtl/ex_mulseq_ctrl.sv
// ex_mulseq_ctrl: iterative 16-step shift-and-add multiply sequencer that
// borrows the shared execute-stage ALU. While it owns the ALU it stalls the
// pipeline and drives acc + mcand through the ALU one step per cycle.
//
// Optional build macro: MULSEQ_EARLY_EXIT_EN
//   defined   -> finish as soon as the remaining multiplier bits are all zero
//   undefined -> always run exactly STEPS iterations
//
// Handshake: start is a level request sampled only in IDLE and accepted when
// flush is low; done is a one-cycle pulse and result then holds until the
// next completion. start seen while busy is ignored; nothing is queued.
module ex_mulseq_ctrl #(
  parameter logic [3:0] ADD_OP = 4'h4,
  parameter int         STEPS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] alu_out,
  output logic        alu_own,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  localparam int CW = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state_q is deliberately left visible for hierarchical checkers
  state_t          state_q, state_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     mcand_q, mcand_d;
  logic [15:0]     mplier_q, mplier_d;
  logic [15:0]     result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            last_step;

  // Next-state and datapath update for the whole sequencer
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    accept    = (state_q == IDLE) && start && !flush;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = 16'h0000;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          // squash: drop the operation, leave result untouched
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) acc_d = alu_out;
          mcand_d   = {mcand_q[14:0], 1'b0};
          mplier_d  = {1'b0, mplier_q[15:1]};
          cnt_d     = cnt_q + 1'b1;
          last_step = (cnt_q == CW'(STEPS - 1));
`ifdef MULSEQ_EARLY_EXIT_EN
          // no multiplier bits left means no further accumulates can occur
          last_step = last_step || (mplier_d == 16'h0000);
`endif
          if (last_step) begin
            // capture the final accumulate so result is valid in DONE
            result_d = acc_d;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      result_q <= 16'h0000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decoded from the registered state; stall also covers the
  // accepting cycle so the multiply instruction is held in EX
  assign alu_own = (state_q == RUN);
  assign alu_a   = alu_own ? acc_q : 16'h0000;
  assign alu_b   = alu_own ? mcand_q : 16'h0000;
  assign alu_op  = alu_own ? ADD_OP : 4'h0;
  assign stall   = accept || (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign result  = result_q;

endmodule

// File: tb/tb_ex_mulseq_ctrl.sv
// tb_ex_mulseq_ctrl: self-checking bench for ex_mulseq_ctrl. The bench plays
// the execute-stage ALU (plain A+B) and predicts every cycle of a run from
// the arithmetic of shift-and-add: before step i the accumulator holds
// a * (b mod 2^i) and the B operand holds a << i, both modulo 2^16.
module tb_ex_mulseq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] alu_out;
  logic        alu_own;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_q[$];
  logic [15:0] last_res;

  ex_mulseq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .op_a    (op_a),
    .op_b    (op_b),
    .alu_out (alu_out),
    .alu_own (alu_own),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the shared ALU the sequencer borrows
  assign alu_out = alu_a + alu_b;

  // single comparison point
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference: number of RUN cycles for a given multiplier
  function automatic int run_len(input logic [15:0] b);
    int n;
`ifdef MULSEQ_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
`else
    n = 16;
`endif
    return n;
  endfunction

  function automatic logic [15:0] acc_before(input logic [15:0] a,
                                             input logic [15:0] b, input int i);
    logic [31:0] mask;
    logic [31:0] prod;
    mask = (32'd1 << i) - 32'd1;
    prod = 32'(a) * (32'(b) & mask);
    return prod[15:0];
  endfunction

  function automatic logic [15:0] mcand_at(input logic [15:0] a, input int i);
    logic [31:0] s;
    s = 32'(a) << i;
    return s[15:0];
  endfunction

  // full multiply with cycle-accurate checks; poke_cyc>0 pulses a stray
  // start (1*1) during that RUN cycle, which must be ignored
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input int poke_cyc);
    int          nrun;
    int          done_cnt;
    logic [31:0] p;
    p    = 32'(a) * 32'(b);
    exp_q.push_back(p[15:0]);
    nrun = run_len(b);
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    #1;
    check_eq("accept_stall", {31'd0, stall}, 32'd1);
    check_eq("accept_own", {31'd0, alu_own}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= nrun + 2; cyc++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (done) done_cnt++;
      if (cyc <= nrun) begin
        check_eq("run_own", {31'd0, alu_own}, 32'd1);
        check_eq("run_stall", {31'd0, stall}, 32'd1);
        check_eq("run_op", {28'd0, alu_op}, 32'h4);
        check_eq("run_a", {16'd0, alu_a}, {16'd0, acc_before(a, b, cyc - 1)});
        check_eq("run_b", {16'd0, alu_b}, {16'd0, mcand_at(a, cyc - 1)});
        if (cyc == poke_cyc) begin
          start = 1'b1;
          op_a  = 16'h0001;
          op_b  = 16'h0001;
        end
      end else if (cyc == nrun + 1) begin
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("done_stall", {31'd0, stall}, 32'd0);
        check_eq("done_own", {31'd0, alu_own}, 32'd0);
        check_eq("done_busy", {31'd0, busy}, 32'd1);
        last_res = exp_q.pop_front();
        check_eq("result", {16'd0, result}, {16'd0, last_res});
      end else begin
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("result_hold", {16'd0, result}, {16'd0, last_res});
      end
    end
    check_eq("done_count", done_cnt, 1);
  endtask

  // start a multiply and squash it with flush during RUN cycle fc
  task automatic run_flush(input logic [15:0] a, input logic [15:0] b,
                           input int fc);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= fc; cyc++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", {31'd0, busy}, 32'd0);
    check_eq("flush_stall", {31'd0, stall}, 32'd0);
    check_eq("flush_result", {16'd0, result}, {16'd0, last_res});
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("flush_nodone", done_cnt, 0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    n_checks = 0;
    n_fail   = 0;
    last_res = 16'h0000;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_a  = 16'h0000;
    op_b  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_own", {31'd0, alu_own}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {16'd0, result}, 32'd0);
    check_eq("rst_op", {28'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_mul(16'd3, 16'd5, 0);
    run_mul(16'hFFFF, 16'hFFFF, 0);
    run_mul(16'h0100, 16'h0100, 0);
    run_mul(16'd7, 16'd9, 0);
    run_flush(16'd2, 16'd2, 5);
    run_mul(16'd4, 16'd4, 3);
    run_mul(16'd10, 16'd3, 0);
    run_mul(16'hABCD, 16'h0000, 0);
    run_mul(16'h1234, 16'h8000, 0);

    // flush in IDLE rejects a simultaneous start
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    #1 check_eq("idle_flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check_eq("idle_flush_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    flush = 1'b0;

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'd5;
    op_b  = 16'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_stall", {31'd0, stall}, 32'd0);
    check_eq("arst_own", {31'd0, alu_own}, 32'd0);
    check_eq("arst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = 16'h0000;
    run_mul(16'd2, 16'd3, 0);

    // randomized operands, multiplier widths spread for varied run lengths
    for (int k = 0; k < 24; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      run_mul(ra, rb, (k % 3 == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mulseq_ctrl.md
Name: ex_mulseq_ctrl

Overview: Iterative multiply sequencer that borrows the shared execute-stage ALU to run a 16-step shift-and-add multiply.
- Takes the start request from decode/execute control.
- Stalls the pipeline while it owns the ALU.
- Steers the ALU operand mux to itself during the run, then presents the low 16 bits of the product for writeback.
- Sits beside the execute-stage ALU, upstream of the ALU operand mux.

Parameters:
ADD_OP, 4'h4, ALU Op encoding for plain A+B; driven on alu_op while the sequencer owns the ALU.
STEPS, 16, number of multiply iterations; must equal the operand width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  multiply request; sampled only in IDLE
flush  in  1  pipeline squash; aborts any operation in progress
op_a  in  16  multiplicand; latched on accepted start
op_b  in  16  multiplier; latched on accepted start
alu_out  in  16  ALU result for the operands driven this cycle
alu_own  out  1  1 = ALU operand mux selects alu_a/alu_b/alu_op from this block
alu_a  out  16  ALU A operand (running accumulator)
alu_b  out  16  ALU B operand (shifted multiplicand)
alu_op  out  4  ADD_OP while alu_own=1, else 0
stall  out  1  holds the IF/ID/EX pipeline registers
busy  out  1  state != IDLE
done  out  1  one-cycle pulse; result is valid
result  out  16  low 16 bits of op_a*op_b; holds until the next completion

Behaviour:
- Reset, asynchronous, from any state:
  - State goes to IDLE.
  - acc, mcand, mplier, cnt and result all become 0.
  - Every output is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start is accepted when start=1 and flush=0. On acceptance: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, go to RUN.
  - stall is combinationally 1 during the accepting cycle, so the instruction is held in EX.
- RUN, one iteration per cycle:
  - Outputs: alu_own=1, alu_a=acc, alu_b=mcand, alu_op=ADD_OP.
  - If mplier[0]=1, acc<=alu_out; otherwise acc is unchanged.
  - mcand<=mcand<<1, dropping bit 15. mplier<=mplier>>1, zero-filled. cnt<=cnt+1.
  - When cnt==STEPS-1, go to DONE.
  - Arithmetic is modulo 2^16; ALU overflow is ignored.
- DONE, lasts one cycle:
  - result<=acc (registered on entry, so it is visible in the DONE cycle). done=1, stall=0, alu_own=0, go to IDLE.
- stall = (IDLE and accepted start) or RUN.
- busy = RUN or DONE.
- Latency: start accepted in cycle 0; RUN occupies cycles 1..16; done=1 in cycle 17; back in IDLE in cycle 18.
- start while busy is ignored. No queueing; the requester keeps start high until it sees done.
- flush:
  - In RUN: next state is IDLE, no done pulse, result unchanged.
  - In IDLE: a simultaneous start is rejected.
  - In DONE: done still pulses; flush has no further effect.
- alu_own is 0 in IDLE and DONE, so the pipeline regains the ALU in the DONE cycle.

Optional Feature:
MULSEQ_EARLY_EXIT_EN
- Defined: in RUN, also go to DONE when the post-shift mplier is 0. The current step's accumulate still completes. Latency becomes (index of the highest set bit of op_b)+1 RUN cycles, minimum 1. op_b=0 gives 1 RUN cycle and done in cycle 2.
- Undefined: always exactly STEPS RUN cycles.
- The result value is identical either way.

Test Plan:
- Reset, then start with op_a=3, op_b=5 → stall=1 in cycles 0-16, alu_own=1 in cycles 1-16, done=1 only in cycle 17, result=0x000F.
- op_a=0xFFFF, op_b=0xFFFF → result=0x0001 (low half); op_a=0x0100, op_b=0x0100 → result=0x0000 (truncation).
- Run 7*9 (result=0x003F); start 2*2 and assert flush in RUN cycle 5 → IDLE next cycle, no done, result stays 0x003F, stall=0.
- During a run of 4*4, pulse start with op_a=1, op_b=1 → ignored; result=0x0010.
- Assert rst asynchronously mid-RUN → busy, stall, alu_own and result are 0 immediately; a new start of 2*3 afterwards yields 0x0006.
- With MULSEQ_EARLY_EXIT_EN defined, op_a=10, op_b=3 → 2 RUN cycles, done in cycle 3, result=0x001E. With op_b=0 → done in cycle 2, result=0.
